// File: rtl/cache_responder.sv
// rtl/cache_responder.sv - direct-mapped read-only word cache answering processor fetches, refilling from memory
// Define CACHE_STATS_EN for saturating hit/miss counters; without it both counter ports read as zero.
module cache_responder #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              rvalid,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int TAG_W = ADDR_W - INDEX_W - 2;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {S_LOOKUP, S_COMPARE, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-3:0]  req_word_q, req_word_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               rvalid_q, rvalid_d;
   logic               mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               flush_pend_q, flush_pend_d;
   logic [TAG_W-1:0]   tag_mem [LINES];
   logic [DATA_W-1:0]  data_mem [LINES];
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic               hit;
   logic               line_wr;
   logic               unused_addr_lsbs;

   assign unused_addr_lsbs = ^addr[1:0];
   assign req_idx = req_word_q[INDEX_W-1:0];
   assign req_tag = req_word_q[ADDR_W-3:INDEX_W];
   assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   always_comb begin
      state_d      = state_q;
      req_word_d   = req_word_q;
      valid_d      = valid_q;
      data_d       = data_q;
      rvalid_d     = 1'b0;
      mem_req_d    = 1'b0;
      mem_addr_d   = mem_addr_q;
      flush_pend_d = flush_pend_q | flush;
      line_wr      = 1'b0;
      case (state_q)
         S_LOOKUP: begin
            // A flush seen mid-access is remembered so it also kills the line just refilled.
            if (flush || flush_pend_q) begin
               valid_d      = '0;
               flush_pend_d = 1'b0;
            end else begin
               req_word_d = addr[ADDR_W-1:2];
               state_d    = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit) begin
               data_d   = data_mem[req_idx];
               rvalid_d = 1'b1;
               state_d  = S_RESP;
            end else begin
               mem_addr_d = {req_word_q, 2'b00};
               mem_req_d  = 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               line_wr          = 1'b1;
               valid_d[req_idx] = 1'b1;
               data_d           = mem_rdata;
               rvalid_d         = 1'b1;
               state_d          = S_RESP;
            end
         end
         default: state_d = S_LOOKUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_LOOKUP;
         req_word_q   <= '0;
         valid_q      <= '0;
         data_q       <= '0;
         rvalid_q     <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_word_q   <= req_word_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         rvalid_q     <= rvalid_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (line_wr) begin
         tag_mem[req_idx]  <= req_tag;
         data_mem[req_idx] <= mem_rdata;
      end
   end

   assign data     = data_q;
   assign rvalid   = rvalid_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

`ifdef CACHE_STATS_EN
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == S_COMPARE) begin
         if (hit && (hit_cnt_q != '1))
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
         if (!hit && (miss_cnt_q != '1))
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_responder.sv
// tb/tb_cache_responder.sv - scoreboard bench for cache_responder with a fixed-latency memory model
// Counter expectations follow CACHE_STATS_EN.
module tb_cache_responder;
   localparam int MEM_LAT = 3;
`ifdef CACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          hit;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] addr = 32'h0;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] data;
   logic        rvalid;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          exp_hit = 0;
   int          exp_miss = 0;
   int          req_count = 0;
   int          resp_cycle = 0;
   int          stale_req = 0;
   logic [31:0] last_maddr = 32'h0;
   bit          addr_stable = 1'b0;
   exp_t        sb[$];

   bit          obs_rv;
   bit          obs_single;
   logic [31:0] obs_data;
   int          obs_lat;
   int          obs_gap;
   int          obs_reqs;

   cache_responder dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .data       (data),
      .rvalid     (rvalid),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h0000_1111);
   endfunction

   // Memory model: answers each mem_req MEM_LAT cycles later, drops it on reset.
   initial begin : memory_model
      bit busy;
      int cnt;
      int stale_ack;
      busy = 1'b0; cnt = 0; stale_ack = 0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      forever begin
         @(negedge clk); #1;
         mem_rvalid = 1'b0;
         if (rst) begin
            busy = 1'b0;
         end else if (stale_req != stale_ack) begin
            stale_ack  = stale_req;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h12345678;
         end else if (mem_req) begin
            req_count++;
            last_maddr = mem_addr;
            busy = 1'b1;
            cnt  = MEM_LAT;
         end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
               busy        = 1'b0;
               mem_rvalid  = 1'b1;
               mem_rdata   = mem_val(last_maddr);
               addr_stable = (mem_addr === last_maddr);
               resp_cycle  = cyc;
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_hit = 0;
      exp_miss = 0;
      sb.delete();
   endtask

   // Drives one processor access from a LOOKUP-cycle negedge and returns at the next LOOKUP negedge.
   task automatic access(input logic [31:0] a, input bit hit);
      exp_t e;
      int   t0;
      int   r0;
      e.addr = a; e.data = mem_val(a); e.hit = hit;
      sb.push_back(e);
      if (hit) exp_hit++; else exp_miss++;
      r0 = req_count;
      t0 = cyc;
      addr = a;
      obs_rv = 1'b0; obs_data = 32'h0; obs_lat = -1; obs_gap = -1;
      for (int i = 0; i < 40 && !obs_rv; i++) begin
         @(negedge clk);
         if (rvalid) begin
            obs_rv   = 1'b1;
            obs_data = data;
            obs_lat  = cyc - t0;
            obs_gap  = cyc - resp_cycle;
         end
      end
      obs_reqs = req_count - r0;
      @(negedge clk);
      obs_single = !rvalid;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (data !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", data); end
      n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      n_cmp++; if (hit_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_hit_cnt got=%0d exp=0", hit_cnt); end
      n_cmp++; if (miss_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt); end
   endtask

   task automatic test_miss();
      exp_t e;
      access(32'h10, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (obs_rv !== 1'b1) begin n_bad++; $display("FAIL miss_rvalid got=%b exp=1", obs_rv); end
      n_cmp++; if (obs_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL miss_data got=%h exp=deadbeef", obs_data); end
      n_cmp++; if (obs_reqs !== 1) begin n_bad++; $display("FAIL miss_req_count got=%0d exp=1", obs_reqs); end
      n_cmp++; if (last_maddr !== e.addr) begin n_bad++; $display("FAIL miss_mem_addr got=%h exp=%h", last_maddr, e.addr); end
      n_cmp++; if (addr_stable !== 1'b1) begin n_bad++; $display("FAIL miss_mem_addr_stable got=%b exp=1", addr_stable); end
      n_cmp++; if (obs_gap !== 1) begin n_bad++; $display("FAIL miss_latency got=%0d exp=1 cycle after mem_rvalid", obs_gap); end
      n_cmp++; if (obs_single !== 1'b1) begin n_bad++; $display("FAIL miss_rvalid_pulse got=%b exp=1", obs_single); end
      n_cmp++; if (miss_cnt !== (STATS ? 16'(exp_miss) : 16'd0)) begin n_bad++; $display("FAIL miss_cnt got=%0d exp=%0d", miss_cnt, STATS ? exp_miss : 0); end
   endtask

   task automatic test_hit();
      exp_t e;
      access(32'h10, 1'b1);
      e = sb.pop_front();
      n_cmp++; if (obs_rv !== 1'b1) begin n_bad++; $display("FAIL hit_rvalid got=%b exp=1", obs_rv); end
      n_cmp++; if (obs_data !== e.data) begin n_bad++; $display("FAIL hit_data got=%h exp=%h", obs_data, e.data); end
      n_cmp++; if (obs_reqs !== 0) begin n_bad++; $display("FAIL hit_req_count got=%0d exp=0", obs_reqs); end
      n_cmp++; if (obs_lat !== 2) begin n_bad++; $display("FAIL hit_latency got=%0d exp=2", obs_lat); end
      n_cmp++; if (obs_single !== 1'b1) begin n_bad++; $display("FAIL hit_rvalid_pulse got=%b exp=1", obs_single); end
      n_cmp++; if (hit_cnt !== (STATS ? 16'(exp_hit) : 16'd0)) begin n_bad++; $display("FAIL hit_cnt got=%0d exp=%0d", hit_cnt, STATS ? exp_hit : 0); end
   endtask

   task automatic test_conflict();
      exp_t        e;
      logic [31:0] seq [2];
      seq[0] = 32'h50; seq[1] = 32'h10;
      for (int i = 0; i < 2; i++) begin
         access(seq[i], 1'b0);
         e = sb.pop_front();
         n_cmp++; if (obs_data !== e.data) begin n_bad++; $display("FAIL conflict_data addr=%h got=%h exp=%h", e.addr, obs_data, e.data); end
         n_cmp++; if (obs_reqs !== 1) begin n_bad++; $display("FAIL conflict_miss addr=%h got=%0d reqs exp=1", e.addr, obs_reqs); end
         n_cmp++; if (last_maddr !== e.addr) begin n_bad++; $display("FAIL conflict_mem_addr got=%h exp=%h", last_maddr, e.addr); end
      end
   endtask

   task automatic test_flush();
      exp_t e;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      access(32'h10, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (obs_reqs !== 1) begin n_bad++; $display("FAIL flush_lookup_miss got=%0d reqs exp=1", obs_reqs); end
      n_cmp++; if (obs_data !== e.data) begin n_bad++; $display("FAIL flush_lookup_data got=%h exp=%h", obs_data, e.data); end
      fork
         access(32'h20, 1'b0);
         begin
            repeat (3) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
         end
      join
      e = sb.pop_front();
      n_cmp++; if (obs_data !== e.data) begin n_bad++; $display("FAIL flush_wait_data got=%h exp=%h", obs_data, e.data); end
      n_cmp++; if (obs_gap !== 1) begin n_bad++; $display("FAIL flush_wait_latency got=%0d exp=1", obs_gap); end
      access(32'h20, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (obs_reqs !== 1) begin n_bad++; $display("FAIL flush_deferred_miss got=%0d reqs exp=1", obs_reqs); end
      n_cmp++; if (obs_data !== e.data) begin n_bad++; $display("FAIL flush_deferred_data got=%h exp=%h", obs_data, e.data); end
   endtask

   task automatic test_reset_wait();
      exp_t e;
      access(32'h10, 1'b0);
      e = sb.pop_front();
      access(32'h10, 1'b1);
      e = sb.pop_front();
      n_cmp++; if (obs_reqs !== 0) begin n_bad++; $display("FAIL rstwait_precached got=%0d reqs exp=0", obs_reqs); end
      addr = 32'h34;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      stale_req++;
      exp_hit = 0;
      exp_miss = 0;
      n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rstwait_rvalid got=%b exp=0", rvalid); end
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rstwait_mem_req got=%b exp=0", mem_req); end
      access(32'h10, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (obs_data !== e.data) begin n_bad++; $display("FAIL rstwait_data got=%h exp=%h", obs_data, e.data); end
      n_cmp++; if (obs_reqs !== 1) begin n_bad++; $display("FAIL rstwait_miss got=%0d reqs exp=1", obs_reqs); end
      n_cmp++; if (obs_gap !== 1) begin n_bad++; $display("FAIL rstwait_latency got=%0d exp=1", obs_gap); end
      n_cmp++; if (miss_cnt !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL rstwait_miss_cnt got=%0d exp=%0d", miss_cnt, STATS ? 1 : 0); end
      n_cmp++; if (hit_cnt !== 16'd0) begin n_bad++; $display("FAIL rstwait_hit_cnt got=%0d exp=0", hit_cnt); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 10; i++) begin
            access(32'(i * 4), pass == 1);
            e = sb.pop_front();
            n_cmp++; if (obs_data !== e.data) begin n_bad++; $display("FAIL loop_data pass=%0d addr=%h got=%h exp=%h", pass, e.addr, obs_data, e.data); end
            n_cmp++; if (obs_reqs !== (e.hit ? 0 : 1)) begin n_bad++; $display("FAIL loop_reqs pass=%0d addr=%h got=%0d exp=%0d", pass, e.addr, obs_reqs, e.hit ? 0 : 1); end
         end
      end
      n_cmp++; if (obs_single !== 1'b1) begin n_bad++; $display("FAIL loop_rvalid_pulse got=%b exp=1", obs_single); end
      n_cmp++; if (hit_cnt !== (STATS ? 16'd10 : 16'd0)) begin n_bad++; $display("FAIL loop_hit_cnt got=%0d exp=%0d", hit_cnt, STATS ? 10 : 0); end
      n_cmp++; if (miss_cnt !== (STATS ? 16'd10 : 16'd0)) begin n_bad++; $display("FAIL loop_miss_cnt got=%0d exp=%0d", miss_cnt, STATS ? 10 : 0); end
   endtask

   initial begin
      test_reset();
      test_miss();
      test_hit();
      test_conflict();
      test_flush();
      test_reset_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
